apr_event_flags: RTL and testbench
==================================

# apr_event_flags

Parametrised APR event/interrupt flag bank for the EBOX. It holds NCHAN sticky event flags, each with its own interrupt enable, and selects edge or level capture per channel. A CONO-style operation port sets, clears, enables or disables channels by bit mask. It raises one registered interrupt request on the programmed PI assignment, reports the lowest pending channel, and provides a diagnostic readback port.

## Interface
Parameters:
- NCHAN, 8: number of event channels (2..32).
- EDGE_MASK, {NCHAN{1'b0}}: per-channel capture mode; bit=1 rising-edge capture, bit=0 level capture.
- CNT_W, 4: width of per-channel occurrence counters (used only with APR_EVENT_COUNT_EN).

Ports:
- clk  in  1  EBOX APR clock; all state on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- ev_in  in  NCHAN  raw event sources (MBOX errors, power warn, sweep busy, ...), synchronous to clk.
- op_valid  in  1  CONO strobe; op bits act only when high.
- op_en, op_dis, op_set, op_clr  in  1 each  operation bits; any combination may be set in one strobe.
- op_mask  in  NCHAN  channel select mask for the operation.
- pia_wr  in  1  load PI assignment.
- pia_data  in  3  new PI assignment level.
- flags  out  NCHAN  sticky event flags.
- int_en  out  NCHAN  interrupt enables.
- pia  out  3  current PI assignment.
- irq  out  1  registered interrupt request.
- irq_chan  out  $clog2(NCHAN)  lowest-index pending enabled channel (registered).
- diag_sel  in  2  readback select.
- diag_chan  in  $clog2(NCHAN)  channel for counter readback.
- diag_data  out  NCHAN  combinational readback.

## Operation
- Detect per channel: det[i] = EDGE_MASK[i] ? ev_in[i] & ~ev_prev[i] : ev_in[i]. ev_prev registers ev_in every cycle.
- Flag next state: flags[i] <= det[i] | (valid & op_set & mask[i]) | (flags[i] & ~(valid & op_clr & mask[i])).
  - A hardware event always wins over a clear, so no event is lost.
  - Set wins over clear.
- Enable next state: int_en[i] <= (valid & op_en & mask[i]) | (int_en[i] & ~(valid & op_dis & mask[i])). Enable wins over disable.
- Channels with mask bit 0 are untouched by the operation.
- pia <= pia_data on pia_wr. It is independent of op_valid, and both may be given in one cycle.
- Pending vector p = flags & int_en, using registered values.
- irq <= |p & (pia != 0). PIA 0 disables the request and leaves the flags intact.
- irq_chan <= index of the lowest set bit of p, or 0 when p = 0.
- diag_data by diag_sel:
  - 0: flags.
  - 1: int_en.
  - 2: det, the current-cycle detected events.
  - 3: counter[diag_chan] zero-extended, or all zeros when APR_EVENT_COUNT_EN is absent.
- If NCHAN < CNT_W, the counter readback is truncated to NCHAN bits.

## Timing
- Reset (RESET_N low, asynchronous): flags, int_en, pia, ev_prev, irq, irq_chan and counters all go to 0.
- At reset release, an edge channel whose input is already high counts as a rising edge on the first clock.
- Latency from an ev_in cycle: flag visible at the next posedge (1 cycle); irq/irq_chan one cycle later (2 cycles).
- Latency from a CONO set with the channel enabled and pia != 0: flag after 1 cycle, irq after 2 cycles.
- Clearing the last pending flag drops irq 2 cycles after the strobe.
- Disabling the channel drops irq 2 cycles after the strobe.
- Setting pia = 0 drops irq 1 cycle after pia_wr.
- Level channel held high: the flag re-sets every cycle, so a CONO clear has no effect while the input stays high.
- Edge channel held high: sets the flag once only.
- Reset asserted mid-operation: state clears immediately. op/pia inputs sampled in that cycle are discarded.

## Configuration
- APR_EVENT_COUNT_EN defined:
  - Each channel has a CNT_W-bit saturating counter.
  - The counter increments on every cycle det[i] = 1 and saturates at 2^CNT_W-1.
  - It is reset to 0 by a CONO clear of that channel.
  - If clear and det occur in the same cycle, the counter becomes 1.
  - The counter is readable via diag_sel = 3.
- APR_EVENT_COUNT_EN undefined: no counters are built, and diag_sel = 3 returns 0.

## Test plan
- Reset, then op_en mask 8'h01 and pia_wr 3'd5. Pulse ev_in[0] for 1 cycle → flags = 8'h01 after 1 cycle; irq = 1, irq_chan = 0 after 2 cycles; pia = 5.
- Edge channel 7 (EDGE_MASK = 8'h80) held high for 10 cycles, then cleared via op_clr mask 8'h80 → flags[7] sets once and clears after the strobe; the counter reads 1.
- Level channel 3 held high while op_clr mask 8'h08 is strobed → flags[3] stays 1. Drop ev_in[3], clear again → 0.
- Same-cycle op_set|op_clr on mask 8'h04, and op_en|op_dis on 8'h04 → flags[2] = 1 and int_en[2] = 1.
- Channels 2 and 5 pending and enabled, pia = 3 → irq_chan = 2. Clear channel 2 → irq_chan = 5. Then pia_wr 0 → irq = 0 with flags unchanged.
- With APR_EVENT_COUNT_EN and CNT_W = 4, 20 events on level channel 1 → diag_sel = 3, diag_chan = 1 reads 15. Assert RESET_N low mid-burst → all outputs 0 asynchronously.

Source files
------------

// File: rtl/apr_event_flags.sv
// APR event/interrupt flag bank: sticky per-channel flags, enables, PI-level irq.
// Optional APR_EVENT_COUNT_EN builds a saturating occurrence counter per channel.

module apr_event_chan #(
    parameter bit EDGE  = 1'b0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             ev,
    input  logic             set,
    input  logic             clr,
    input  logic             en_set,
    input  logic             dis,
    output logic             det,
    output logic             flag,
    output logic             en,
    output logic [CNT_W-1:0] cnt
);
    logic ev_prev;

    assign det = EDGE ? (ev & ~ev_prev) : ev;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            ev_prev <= 1'b0;
            flag    <= 1'b0;
            en      <= 1'b0;
        end else begin
            ev_prev <= ev;
            // hardware event beats clear; set beats clear; enable beats disable
            flag    <= det | set | (flag & ~clr);
            en      <= en_set | (en & ~dis);
        end
    end

`ifdef APR_EVENT_COUNT_EN
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N)
            cnt <= '0;
        else if (clr)
            cnt <= {{(CNT_W-1){1'b0}}, det};
        else if (det && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end
`else
    assign cnt = '0;
`endif
endmodule

module apr_event_flags #(
    parameter int               NCHAN     = 8,
    parameter logic [NCHAN-1:0] EDGE_MASK = {NCHAN{1'b0}},
    parameter int               CNT_W     = 4,
    localparam int              IDX_W     = $clog2(NCHAN)
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [NCHAN-1:0] ev_in,
    input  logic             op_valid,
    input  logic             op_en,
    input  logic             op_dis,
    input  logic             op_set,
    input  logic             op_clr,
    input  logic [NCHAN-1:0] op_mask,
    input  logic             pia_wr,
    input  logic [2:0]       pia_data,
    output logic [NCHAN-1:0] flags,
    output logic [NCHAN-1:0] int_en,
    output logic [2:0]       pia,
    output logic             irq,
    output logic [IDX_W-1:0] irq_chan,
    input  logic [1:0]       diag_sel,
    input  logic [IDX_W-1:0] diag_chan,
    output logic [NCHAN-1:0] diag_data
);
    logic [NCHAN-1:0]            mask_v;
    logic [NCHAN-1:0]            det;
    logic [NCHAN-1:0]            pend;
    logic [NCHAN-1:0][CNT_W-1:0] cnt_all;
    logic [CNT_W-1:0]            sel_cnt;
    logic [IDX_W-1:0]            low_idx;
    logic [2:0]                  pia_next;

    assign mask_v = op_valid ? op_mask : '0;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        apr_event_chan #(
            .EDGE  (EDGE_MASK[g]),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .RESET_N (RESET_N),
            .ev      (ev_in[g]),
            .set     (op_set & mask_v[g]),
            .clr     (op_clr & mask_v[g]),
            .en_set  (op_en  & mask_v[g]),
            .dis     (op_dis & mask_v[g]),
            .det     (det[g]),
            .flag    (flags[g]),
            .en      (int_en[g]),
            .cnt     (cnt_all[g])
        );
    end

    assign pend     = flags & int_en;
    // irq looks at the PIA being loaded so a write of 0 masks the request on the next edge
    assign pia_next = pia_wr ? pia_data : pia;

    always_comb begin
        low_idx = '0;
        for (int i = NCHAN - 1; i >= 0; i--)
            if (pend[i]) low_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pia      <= '0;
            irq      <= 1'b0;
            irq_chan <= '0;
        end else begin
            pia      <= pia_next;
            irq      <= (|pend) & (pia_next != 3'd0);
            irq_chan <= low_idx;
        end
    end

    always_comb begin
        sel_cnt = '0;
        if (int'(diag_chan) < NCHAN) sel_cnt = cnt_all[diag_chan];
        case (diag_sel)
            2'd0:    diag_data = flags;
            2'd1:    diag_data = int_en;
            2'd2:    diag_data = det;
            default: diag_data = NCHAN'(sel_cnt);
        endcase
    end
endmodule

// File: tb/tb_apr_event_flags.sv
// Scoreboard bench for apr_event_flags: reference model predicts every cycle,
// a negedge monitor pops and compares; directed test-plan steps then random traffic.

module tb_apr_event_flags;
    localparam int         N     = 8;
    localparam logic [7:0] EM    = 8'h80;
    localparam int         CNT_W = 4;
    localparam int         CMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [7:0] ev_in;
    logic       op_valid, op_en, op_dis, op_set, op_clr;
    logic [7:0] op_mask;
    logic       pia_wr;
    logic [2:0] pia_data;
    logic [7:0] flags, int_en;
    logic [2:0] pia;
    logic       irq;
    logic [2:0] irq_chan;
    logic [1:0] diag_sel;
    logic [2:0] diag_chan;
    logic [7:0] diag_data;

    apr_event_flags #(.NCHAN(N), .EDGE_MASK(EM), .CNT_W(CNT_W)) dut (
        .clk(clk), .RESET_N(RESET_N), .ev_in(ev_in),
        .op_valid(op_valid), .op_en(op_en), .op_dis(op_dis), .op_set(op_set), .op_clr(op_clr),
        .op_mask(op_mask), .pia_wr(pia_wr), .pia_data(pia_data),
        .flags(flags), .int_en(int_en), .pia(pia), .irq(irq), .irq_chan(irq_chan),
        .diag_sel(diag_sel), .diag_chan(diag_chan), .diag_data(diag_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] flags;
        logic [7:0] en;
        logic [2:0] pia;
        logic       irq;
        logic [2:0] chan;
        logic [7:0] diag;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // reference model: one entry per channel, plain integers
    bit m_flag[N];
    bit m_en[N];
    bit m_prev[N];
    int m_cnt[N];
    int m_pia;
    bit m_irq;
    int m_chan;

    function automatic bit m_det(int i);
        if (EM[i]) return ev_in[i] && !m_prev[i];
        return ev_in[i];
    endfunction

    function automatic logic [7:0] pack_bits(bit b[N]);
        logic [7:0] v;
        for (int i = 0; i < N; i++) v[i] = b[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_flag[i] = 0; m_en[i] = 0; m_prev[i] = 0; m_cnt[i] = 0;
        end
        m_pia = 0; m_irq = 0; m_chan = 0;
    endtask

    task automatic model_step();
        bit d[N];
        bit any_p;
        int low;
        if (!RESET_N) return;
        any_p = 0; low = 0;
        for (int i = N - 1; i >= 0; i--)
            if (m_flag[i] && m_en[i]) begin any_p = 1; low = i; end
        if (pia_wr) m_pia = int'(pia_data);
        m_irq  = any_p && (m_pia != 0);
        m_chan = low;
        for (int i = 0; i < N; i++) begin
            bool_step(i, d);
        end
    endtask

    task automatic bool_step(int i, inout bit d[N]);
        bit sel;
        sel  = op_valid && op_mask[i];
        d[i] = m_det(i);
        m_prev[i] = ev_in[i];
        if (d[i] || (sel && op_set))  m_flag[i] = 1;
        else if (sel && op_clr)       m_flag[i] = 0;
        if (sel && op_en)             m_en[i] = 1;
        else if (sel && op_dis)       m_en[i] = 0;
        if (sel && op_clr)            m_cnt[i] = d[i] ? 1 : 0;
        else if (d[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    endtask

    function automatic obs_t predict();
        obs_t e;
        bit   d[N];
        for (int i = 0; i < N; i++) d[i] = m_det(i);
        e.flags = pack_bits(m_flag);
        e.en    = pack_bits(m_en);
        e.pia   = 3'(m_pia);
        e.irq   = m_irq;
        e.chan  = 3'(m_chan);
        case (diag_sel)
            2'd0: e.diag = e.flags;
            2'd1: e.diag = e.en;
            2'd2: e.diag = pack_bits(d);
`ifdef APR_EVENT_COUNT_EN
            default: e.diag = 8'(m_cnt[diag_chan]);
`else
            default: e.diag = 8'h00;
`endif
        endcase
        return e;
    endfunction

    // one clock: queue the prediction for this cycle, then advance the model at the edge
    task automatic tick();
        exp_q.push_back(predict());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic op(bit en, bit dis, bit set, bit clr, logic [7:0] m);
        op_valid = 1; op_en = en; op_dis = dis; op_set = set; op_clr = clr; op_mask = m;
    endtask

    task automatic noop();
        op_valid = 0; op_en = 0; op_dis = 0; op_set = 0; op_clr = 0; op_mask = '0; pia_wr = 0;
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {flags, int_en, pia, irq, irq_chan, diag_data};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t got fl=%h en=%h pia=%0d irq=%b ch=%0d dg=%h want fl=%h en=%h pia=%0d irq=%b ch=%0d dg=%h",
                             $time, a.flags, a.en, a.pia, a.irq, a.chan, a.diag,
                             e.flags, e.en, e.pia, e.irq, e.chan, e.diag);
                end
            end
        end
    end

    initial begin
        RESET_N = 0; ev_in = '0; pia_data = '0; diag_sel = '0; diag_chan = '0;
        noop();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 32'(flags), 0);
        chk("reset_irq", 32'(irq), 0);
        chk("reset_pia", 32'(pia), 0);
        RESET_N = 1;

        // enable ch0, PIA 5, single event pulse
        op(1, 0, 0, 0, 8'h01); pia_wr = 1; pia_data = 3'd5;
        tick();
        noop(); ev_in = 8'h01;
        tick();
        ev_in = '0;
        chk("t1_flags", 32'(flags), 32'h01);
        tick();
        chk("t1_irq", 32'(irq), 1);
        chk("t1_irq_chan", 32'(irq_chan), 0);
        chk("t1_pia", 32'(pia), 5);

        // edge ch7 held high sets once
        ev_in = 8'h80;
        repeat (10) tick();
        chk("t2_flag7", 32'(flags[7]), 1);
        diag_sel = 2'd3; diag_chan = 3'd7;
        #1;
`ifdef APR_EVENT_COUNT_EN
        chk("t2_cnt7", 32'(diag_data), 1);
`else
        chk("t2_cnt7", 32'(diag_data), 0);
`endif
        op(0, 0, 0, 1, 8'h80);
        tick();
        noop(); diag_sel = 2'd0;
        chk("t2_flag7_clr", 32'(flags[7]), 0);

        // level ch3 held high survives a clear
        ev_in = 8'h08;
        tick();
        op(0, 0, 0, 1, 8'h08);
        tick();
        noop();
        chk("t3_flag3_held", 32'(flags[3]), 1);
        ev_in = '0;
        tick();
        op(0, 0, 0, 1, 8'h08);
        tick();
        noop();
        chk("t3_flag3_clr", 32'(flags[3]), 0);

        // set/clr and en/dis together
        op(1, 1, 1, 1, 8'h04);
        tick();
        noop();
        chk("t4_flag2", 32'(flags[2]), 1);
        chk("t4_en2", 32'(int_en[2]), 1);

        // ch2 and ch5 pending, PIA 3
        op(0, 1, 0, 1, 8'hDB);
        tick();
        op(1, 0, 1, 0, 8'h24); pia_wr = 1; pia_data = 3'd3;
        tick();
        noop();
        tick();
        chk("t5_chan2", 32'(irq_chan), 2);
        op(0, 0, 0, 1, 8'h04);
        tick();
        noop();
        tick();
        chk("t5_chan5", 32'(irq_chan), 5);
        pia_wr = 1; pia_data = 3'd0;
        tick();
        pia_wr = 0;
        chk("t5_irq_off", 32'(irq), 0);
        chk("t5_flags_kept", 32'(flags), 32'h20);

        // saturating burst on level ch1, then async reset mid-burst
        ev_in = 8'h02;
        repeat (20) tick();
        diag_sel = 2'd3; diag_chan = 3'd1;
        #1;
`ifdef APR_EVENT_COUNT_EN
        chk("t6_cnt_sat", 32'(diag_data), 15);
`else
        chk("t6_cnt_sat", 32'(diag_data), 0);
`endif
        RESET_N = 0;
        model_reset();
        #1;
        chk("t6_async_rst", 32'({flags, int_en, pia, irq, irq_chan}), 0);
        tick();
        RESET_N = 1; ev_in = '0; diag_sel = '0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            ev_in     = 8'($urandom);
            op_valid  = ($urandom_range(0, 2) == 0);
            op_en     = 1'($urandom); op_dis = 1'($urandom);
            op_set    = 1'($urandom); op_clr = 1'($urandom);
            op_mask   = 8'($urandom);
            pia_wr    = ($urandom_range(0, 7) == 0);
            pia_data  = 3'($urandom);
            diag_sel  = 2'($urandom);
            diag_chan = 3'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                RESET_N = 0;
                model_reset();
            end else begin
                RESET_N = 1;
            end
            tick();
        end
        noop(); RESET_N = 1;
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
